// File: rtl/memory_writeback_stage_if.sv
// rtl/memory_writeback_stage_if.sv - data-memory request/ready bus between the M stage and its responder
interface memory_writeback_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/memory_writeback_stage.sv
// rtl/memory_writeback_stage.sv - M-stage memory access with stall/timeout and the M->W pipeline register
module memory_writeback_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            RegWriteM,
  input  logic                            MemWriteM,
  input  logic [4:0]                      RdM,
  input  logic [1:0]                      ResultSrcM,
  input  logic [31:0]                     ALUResultM,
  input  logic [31:0]                     WriteDataM,
  input  logic [31:0]                     PCPlus4M,
  memory_writeback_stage_if.master        mem,
  output logic                            StallM,
  output logic                            RegWriteW,
  output logic [4:0]                      RdW,
  output logic [31:0]                     ResultW,
  output logic                            mem_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             req_we_q, req_we_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [31:0]      req_wdata_q, req_wdata_d;
  logic             RegWriteW_q, RegWriteW_d;
  logic [4:0]       RdW_q, RdW_d;
  logic [1:0]       ResultSrcW_q, ResultSrcW_d;
  logic [31:0]      ALUResultW_q, ALUResultW_d;
  logic [31:0]      ReadDataW_q, ReadDataW_d;
  logic [31:0]      PCPlus4W_q, PCPlus4W_d;

  logic mem_op;
  logic timeout_hit;
  logic capture;
  logic drop_wr;
  logic take_rdata;

  assign mem_op      = MemWriteM | (ResultSrcM == 2'b01);
  assign timeout_hit = (cnt_q == TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      RegWriteW_q  <= 1'b0;
      RdW_q        <= '0;
      ResultSrcW_q <= '0;
      ALUResultW_q <= '0;
      ReadDataW_q  <= '0;
      PCPlus4W_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      RegWriteW_q  <= RegWriteW_d;
      RdW_q        <= RdW_d;
      ResultSrcW_q <= ResultSrcW_d;
      ALUResultW_q <= ALUResultW_d;
      ReadDataW_q  <= ReadDataW_d;
      PCPlus4W_q   <= PCPlus4W_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    capture     = 1'b0;
    drop_wr     = 1'b0;
    take_rdata  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!mem_op) begin
          capture = 1'b1;
        end else if (mem.mem_ready) begin
          capture    = 1'b1;
          take_rdata = 1'b1;
        end else begin
          state_d     = S_WAIT;
          cnt_d       = CNT_W'(1);
          req_we_d    = MemWriteM;
          req_addr_d  = ALUResultM;
          req_wdata_d = WriteDataM;
        end
      end
      S_WAIT: begin
        if (mem.mem_ready) begin
          capture    = 1'b1;
          take_rdata = 1'b1;
          state_d    = S_IDLE;
          cnt_d      = '0;
        end else if (!timeout_hit) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Abort: let the instruction retire without a register write so the pipeline drains.
          capture = 1'b1;
          drop_wr = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
    endcase

    if (capture) begin
      RegWriteW_d  = RegWriteM & ~drop_wr;
      RdW_d        = RdM;
      ResultSrcW_d = ResultSrcM;
      ALUResultW_d = ALUResultM;
      PCPlus4W_d   = PCPlus4M;
    end else begin
      RegWriteW_d  = 1'b0;
      RdW_d        = '0;
      ResultSrcW_d = '0;
      ALUResultW_d = '0;
      PCPlus4W_d   = '0;
    end
    ReadDataW_d = take_rdata ? mem.mem_rdata : ReadDataW_q;
  end

  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = MemWriteM;
    mem.mem_addr  = ALUResultM;
    mem.mem_wdata = WriteDataM;
    StallM        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        mem.mem_req = mem_op;
        StallM      = mem_op & ~mem.mem_ready;
      end
      S_WAIT: begin
        mem.mem_we    = req_we_q;
        mem.mem_addr  = req_addr_q;
        mem.mem_wdata = req_wdata_q;
        mem.mem_req   = mem.mem_ready | ~timeout_hit;
        StallM        = ~mem.mem_ready & ~timeout_hit;
      end
    endcase
  end

  always_comb begin
    unique case (ResultSrcW_q)
      2'b00:   ResultW = ALUResultW_q;
      2'b01:   ResultW = ReadDataW_q;
      2'b10:   ResultW = PCPlus4W_q;
      default: ResultW = 32'h0;
    endcase
  end

  assign RegWriteW = RegWriteW_q;
  assign RdW       = RdW_q;
  assign mem_err   = err_q;

endmodule
